alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/kgp_alu_pkg.sv | 49 ++++
 rtl/alu_shifter_seq.sv | 58 +++++
 rtl/alu_exec_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/kgp_alu_pkg.sv
// Shared encodings, widths and branch evaluation for the ALU execution unit.
package kgp_alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_AND   = 3'b001,
        OP_XOR   = 3'b010,
        OP_COMP  = 3'b011,
        OP_SHIFT = 3'b100,
        OP_NOP   = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        FL_BLTZ = 3'b000,
        FL_BZ   = 3'b001,
        FL_BNZ  = 3'b010,
        FL_BCY  = 3'b011,
        FL_BNCY = 3'b100,
        FL_NONE = 3'b111
    } flag_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    function automatic logic branch_eval(
        input logic [2:0]        f,
        input logic [DATA_W-1:0] a,
        input logic              cy
    );
        logic t;
        t = 1'b0;
        case (f)
            FL_BLTZ: t = a[DATA_W-1];
            FL_BZ:   t = (a == '0);
            FL_BNZ:  t = (a != '0);
            FL_BCY:  t = cy;
            FL_BNCY: t = ~cy;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_shifter_seq.sv
// Iterative one-bit-per-clock shifter with load, step and count-zero status.
module alu_shifter_seq
    import kgp_alu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] amt_i,
    input  logic               is_log_i,
    input  logic               dir_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               zero_o
);

    logic [DATA_W-1:0]  data_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               log_q;
    logic               dir_q;

    function automatic logic [DATA_W-1:0] shift1(
        input logic [DATA_W-1:0] d,
        input logic              lg,
        input logic              left
    );
        if (left)
            return {d[DATA_W-2:0], 1'b0};
        return {(lg ? 1'b0 : d[DATA_W-1]), d[DATA_W-1:1]};
    endfunction

    // The first bit moves on load so the last bit lands as the count hits zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
            log_q  <= 1'b0;
            dir_q  <= 1'b0;
        end else if (load_i) begin
            log_q <= is_log_i;
            dir_q <= dir_i;
            if (amt_i == '0) begin
                data_q <= data_i;
                cnt_q  <= '0;
            end else begin
                data_q <= shift1(data_i, is_log_i, dir_i);
                cnt_q  <= amt_i - 1'b1;
            end
        end else if (step_i && cnt_q != '0) begin
            data_q <= shift1(data_q, log_q, dir_q);
            cnt_q  <= cnt_q - 1'b1;
        end
    end

    assign data_o = data_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle arithmetic/logic ops, iterative shifts, branch flag.
module alu_exec_unit
    import kgp_alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        opSwitch,
    input  logic [2:0]        flagSwitch,
    input  logic              isLog,
    input  logic              dir,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              branch_taken,
    output logic              busy,
    output logic              done
);

    state_e            state_q;
    logic [2:0]        flag_q;
    logic [DATA_W-1:0] a_q;
    logic              cy_q;
    logic [DATA_W-1:0] result_q;
    logic              carry_q;
    logic              br_q;
    logic              done_q;

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              accept;
    logic              is_shift;
    logic [DATA_W-1:0] sh_data;
    logic              sh_zero;

    assign accept   = start && (state_q == S_IDLE);
    assign is_shift = (opSwitch == OP_SHIFT) && (opB[SHAMT_W-1:0] != '0);

    always_comb begin
        sum     = {1'b0, opA} + {1'b0, opB};
        alu_res = '0;
        case (opSwitch)
            OP_ADD:   alu_res = sum[DATA_W-1:0];
            OP_AND:   alu_res = opA & opB;
            OP_XOR:   alu_res = opA ^ opB;
            OP_COMP:  alu_res = ~opB + 32'd1;
            OP_SHIFT: alu_res = opA;
            default:  alu_res = '0;
        endcase
    end

    alu_shifter_seq u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load_i   (accept && is_shift),
        .step_i   (state_q == S_SHIFT),
        .data_i   (opA),
        .amt_i    (opB[SHAMT_W-1:0]),
        .is_log_i (isLog),
        .dir_i    (dir),
        .data_o   (sh_data),
        .zero_o   (sh_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            flag_q   <= 3'b111;
            a_q      <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            br_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        flag_q <= flagSwitch;
                        a_q    <= opA;
                        cy_q   <= carry_q;
                        if (is_shift) begin
                            state_q <= S_SHIFT;
                        end else begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= alu_res;
                            br_q     <= branch_eval(flagSwitch, opA, carry_q);
                            if (opSwitch == OP_ADD)
                                carry_q <= sum[DATA_W];
                        end
                    end
                end
                S_SHIFT: begin
                    if (sh_zero) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= sh_data;
                        br_q     <= branch_eval(flag_q, a_q, cy_q);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign result       = result_q;
    assign carry        = carry_q;
    assign branch_taken = br_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;

endmodule
